game_judge: RTL and testbench



---
 rtl/game_judge_pkg.sv | 30 +++
 rtl/game_line_lut.sv | 29 ++
 rtl/game_judge.sv | 136 +++++++++++++
 tb/tb_game_judge.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/game_judge_pkg.sv
// Shared codes and the cell-extraction helper for the tic-tac-toe judge.
`default_nettype none

package game_judge_pkg;

  localparam int BOARD_W = 18;

  localparam logic [1:0] CELL_EMPTY   = 2'b00;
  localparam logic [1:0] CELL_X       = 2'b01;
  localparam logic [1:0] CELL_O       = 2'b10;
  localparam logic [1:0] CELL_ILLEGAL = 2'b11;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_XWIN = 2'b01;
  localparam logic [1:0] RES_OWIN = 2'b10;
  localparam logic [1:0] RES_DRAW = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  function automatic logic [1:0] cell_at(input logic [BOARD_W-1:0] b, input logic [3:0] idx);
    cell_at = b[{idx, 1'b0} +: 2];
  endfunction

endpackage

`default_nettype wire

// File: rtl/game_line_lut.sv
// Maps a winning-line index (rows, columns, diagonal, anti-diagonal) to its three cell indices.
`default_nettype none

module game_line_lut (
  input  logic [2:0] line,
  output logic [3:0] cell_a,
  output logic [3:0] cell_b,
  output logic [3:0] cell_c
);

  always_comb begin
    cell_a = 4'd0;
    cell_b = 4'd0;
    cell_c = 4'd0;
    case (line)
      3'd0: begin cell_a = 4'd0; cell_b = 4'd1; cell_c = 4'd2; end
      3'd1: begin cell_a = 4'd3; cell_b = 4'd4; cell_c = 4'd5; end
      3'd2: begin cell_a = 4'd6; cell_b = 4'd7; cell_c = 4'd8; end
      3'd3: begin cell_a = 4'd0; cell_b = 4'd3; cell_c = 4'd6; end
      3'd4: begin cell_a = 4'd1; cell_b = 4'd4; cell_c = 4'd7; end
      3'd5: begin cell_a = 4'd2; cell_b = 4'd5; cell_c = 4'd8; end
      3'd6: begin cell_a = 4'd0; cell_b = 4'd4; cell_c = 4'd8; end
      default: begin cell_a = 4'd2; cell_b = 4'd4; cell_c = 4'd6; end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/game_judge.sv
// Sequential tic-tac-toe judge: snapshots the board and scans one winning line per clock.
// Optional GAME_JUDGE_EARLY_EXIT_EN: stop at the first win and skip double-win detection.
`default_nettype none

module game_judge
  import game_judge_pkg::*;
#(
  parameter int NUM_CELLS = 9,
  parameter int CELL_W    = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_CELLS*CELL_W-1:0] board,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic [1:0]                  result,
  output logic [2:0]                  win_line,
  output logic                        invalid
);

  state_t             state;
  logic [BOARD_W-1:0] snap;
  logic [2:0]         line;
  logic               win_found;
  logic [1:0]         winner;
  logic [2:0]         first_line;
  logic               double_win;

  logic [3:0] cell_a, cell_b, cell_c;
  logic [1:0] va, vb, vc;
  logic       line_win;
  logic       any_illegal;
  logic       any_empty;

  game_line_lut u_lut (
    .line   (line),
    .cell_a (cell_a),
    .cell_b (cell_b),
    .cell_c (cell_c)
  );

  always_comb begin
    va       = cell_at(snap, cell_a);
    vb       = cell_at(snap, cell_b);
    vc       = cell_at(snap, cell_c);
    line_win = (va == vb) && (vb == vc) && ((va == CELL_X) || (va == CELL_O));
  end

  always_comb begin
    any_illegal = 1'b0;
    any_empty   = 1'b0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (cell_at(snap, 4'(i)) == CELL_ILLEGAL) any_illegal = 1'b1;
      if (cell_at(snap, 4'(i)) == CELL_EMPTY)   any_empty   = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      snap       <= '0;
      line       <= 3'd0;
      win_found  <= 1'b0;
      winner     <= CELL_EMPTY;
      first_line <= 3'd0;
      double_win <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= RES_NONE;
      win_line   <= 3'd0;
      invalid    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            snap       <= board;
            line       <= 3'd0;
            win_found  <= 1'b0;
            winner     <= CELL_EMPTY;
            first_line <= 3'd0;
            double_win <= 1'b0;
            busy       <= 1'b1;
            result     <= RES_NONE;
            win_line   <= 3'd0;
            invalid    <= 1'b0;
            state      <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (line_win) begin
            if (!win_found) begin
              win_found  <= 1'b1;
              winner     <= va;
              first_line <= line;
            end
`ifndef GAME_JUDGE_EARLY_EXIT_EN
            else if (va != winner) begin
              double_win <= 1'b1;
            end
`endif
          end
          line <= line + 3'd1;
`ifdef GAME_JUDGE_EARLY_EXIT_EN
          if (line_win || line == 3'd7) state <= ST_REPORT;
`else
          if (line == 3'd7) state <= ST_REPORT;
`endif
        end
        ST_REPORT: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
          // Illegal cells and double wins override any recorded winner.
          if (any_illegal || double_win) begin
            invalid  <= 1'b1;
            result   <= RES_NONE;
            win_line <= 3'd0;
          end else if (win_found) begin
            result   <= (winner == CELL_X) ? RES_XWIN : RES_OWIN;
            win_line <= first_line;
          end else if (!any_empty) begin
            result   <= RES_DRAW;
          end else begin
            result   <= RES_NONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_game_judge.sv
// Randomized self-checking bench for game_judge against a line-table reference model.
`default_nettype none

module tb_game_judge;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [17:0] board = '0;
  logic        start = 1'b0;
  logic        busy, done, invalid;
  logic [1:0]  result;
  logic [2:0]  win_line;

  int n_checks = 0;
  int n_pass   = 0;

  localparam int LINES [0:7][0:2] = '{
    '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
    '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
    '{0, 4, 8}, '{2, 4, 6}
  };

  game_judge #(.NUM_CELLS(9), .CELL_W(2)) dut (
    .clock    (clock),
    .reset    (reset),
    .board    (board),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .win_line (win_line),
    .invalid  (invalid)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference: evaluate every line of the 3x3 grid directly from the rules.
  task automatic model(input logic [17:0] b, output int res, output int wl,
                       output int inv, output int lat);
    int c[9];
    int first, who, dbl, illegal, empty;
    first = -1; who = 0; dbl = 0; illegal = 0; empty = 0;
    for (int i = 0; i < 9; i++) begin
      c[i] = int'(b[2*i +: 2]);
      if (c[i] == 3) illegal = 1;
      if (c[i] == 0) empty = 1;
    end
    for (int k = 0; k < 8; k++) begin
      int a = c[LINES[k][0]];
      if ((a == 1 || a == 2) && c[LINES[k][1]] == a && c[LINES[k][2]] == a) begin
        if (first < 0) begin first = k; who = a; end
        else if (a != who) dbl = 1;
      end
    end
`ifdef GAME_JUDGE_EARLY_EXIT_EN
    dbl = 0;
    lat = (first >= 0) ? first + 2 : 9;
`else
    lat = 9;
`endif
    if (illegal != 0 || dbl != 0) begin res = 0; wl = 0; inv = 1; end
    else if (first >= 0)          begin res = who; wl = first; inv = 0; end
    else if (empty == 0)          begin res = 3; wl = 0; inv = 0; end
    else                          begin res = 0; wl = 0; inv = 0; end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // mode 0 plain, 1 re-assert start mid-scan, 2 scramble board mid-scan
  task automatic run_scan(input string tag, input logic [17:0] b, input int mode);
    int res, wl, inv, lat, n, dones, done_at;
    model(b, res, wl, inv, lat);
    board = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy_on"}, int'(busy), 1);
    check({tag, "_clr_result"}, int'(result), 0);
    dones = 0; done_at = -1;
    for (n = 1; n <= 20; n++) begin
      if (mode == 1 && (n == 2 || n == 3)) start = 1'b1;
      else start = 1'b0;
      if (mode == 2 && n == 3) board = 18'($urandom);
      tick();
      if (done) begin
        dones++;
        if (done_at < 0) begin
          done_at = n;
          check({tag, "_latency"}, n, lat);
          check({tag, "_result"}, int'(result), res);
          check({tag, "_win_line"}, int'(win_line), wl);
          check({tag, "_invalid"}, int'(invalid), inv);
          check({tag, "_busy_off"}, int'(busy), 0);
        end
      end
    end
    if (done_at < 0) check({tag, "_done_timeout"}, 0, 1);
    check({tag, "_one_done"}, dones, 1);
    check({tag, "_held"}, int'(result), res);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_result"}, int'(result), 0);
    check({tag, "_win_line"}, int'(win_line), 0);
    check({tag, "_invalid"}, int'(invalid), 0);
  endtask

  function automatic logic [17:0] rand_board();
    logic [17:0] b;
    for (int i = 0; i < 9; i++) begin
      int r = $urandom_range(0, 31);
      b[2*i +: 2] = (r == 0) ? 2'b11 : (r < 10) ? 2'b00 : (r < 21) ? 2'b01 : 2'b10;
    end
    return b;
  endfunction

  initial begin
    int dones;
    repeat (3) tick();
    check_reset_vals("por");
    reset = 1'b0;
    tick();

    run_scan("x_row",   18'h00015, 0);
    run_scan("o_anti",  18'h02220, 0);
    run_scan("draw",    18'h16A59, 0);
    run_scan("empty",   18'h00000, 0);
    run_scan("illegal", 18'h00300, 0);
    run_scan("dbl_win", 18'h00A95, 0);
    run_scan("restart", 18'h00015, 1);
    run_scan("bchange", 18'h02220, 2);

    // Asynchronous reset in the middle of a scan: outputs clear without a clock edge.
    run_scan("pre_rst", 18'h00A95, 0);
    board = 18'h00015;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    #2 reset = 1'b1;
    #1 check_reset_vals("async_rst");
    tick();
    reset = 1'b0;
    dones = 0;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (done) dones++;
    end
    check("rst_no_done", dones, 0);
    check_reset_vals("post_rst");

    for (int t = 0; t < 40; t++) begin
      run_scan($sformatf("rand%0d", t), rand_board(), t % 3);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
